// File: rtl/exe_mem_backend_pkg.sv
// Shared definitions for the EX/MEM/WB back end: defaults, FSM encoding,
// forwarding-select codes and the EX/MEM control bundle.
package exe_mem_backend_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 4;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_WAIT = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic valid;
        logic wb_en;
        logic r_en;
        logic w_en;
    } exm_ctrl_t;

    function automatic logic is_memop(input exm_ctrl_t c);
        return c.valid & (c.r_en | c.w_en);
    endfunction

endpackage

// File: rtl/exe_mem_backend_mem_fsm.sv
// Data-memory handshake: raises mem_req/stall for a memory op in MEM and
// captures the read data on the completion strobe.
//
// state  | meaning
// M_IDLE | no access outstanding; a memop in MEM starts a request here
// M_WAIT | request outstanding, pipeline frozen until mem_ready
// M_DONE | data captured, pipeline advances for one cycle
module mem_access_fsm
    import exe_mem_backend_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memop,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic [DATA_W-1:0] rdata_q
);

    logic [1:0] state;
    logic [1:0] state_nxt;

    // mem_ready outside M_WAIT is a protocol error and falls through untouched
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        case (state)
            M_IDLE: begin
                if (memop) begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    state_nxt = M_WAIT;
                end
            end
            M_WAIT: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_nxt = M_DONE;
            end
            M_DONE:  state_nxt = M_IDLE;
            default: state_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= M_IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == M_WAIT && mem_ready) rdata_q <= mem_rdata;
        end
    end

endmodule

// File: rtl/exe_mem_backend.sv
// Pipeline back end: operand forwarding mux, EX/MEM and MEM/WB registers,
// and the data-memory access sequencer.
module exe_mem_backend
    import exe_mem_backend_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] ex_val1,
    input  logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] fwd_val1,
    output logic [DATA_W-1:0] fwd_val2,
    input  logic              ex_valid,
    input  logic              ex_wb_en,
    input  logic              ex_mem_r_en,
    input  logic              ex_mem_w_en,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_alu_res,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              MEM_WB_en,
    output logic [REG_AW-1:0] MEM_dest,
    output logic              WB_WB_en,
    output logic [REG_AW-1:0] WB_dest,
    output logic [DATA_W-1:0] mem_stage_val,
    output logic [DATA_W-1:0] wb_value
);

    exm_ctrl_t         exm_ctrl;
    logic [REG_AW-1:0] exm_dest;
    logic [DATA_W-1:0] exm_alu;
    logic [DATA_W-1:0] exm_sd;
    logic [DATA_W-1:0] rdata_q;
    logic              memop;

    always_comb begin
        case (sel_src1)
            FWD_ID:  fwd_val1 = ex_val1;
            FWD_MEM: fwd_val1 = mem_stage_val;
            FWD_WB:  fwd_val1 = wb_value;
            default: fwd_val1 = ex_val1;
        endcase
        case (sel_src2)
            FWD_ID:  fwd_val2 = ex_val2;
            FWD_MEM: fwd_val2 = mem_stage_val;
            FWD_WB:  fwd_val2 = wb_value;
            default: fwd_val2 = ex_val2;
        endcase
    end

    // store data is the forwarded operand, so a store can consume a fresh MEM/WB result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_ctrl <= '0;
            exm_dest <= '0;
            exm_alu  <= '0;
            exm_sd   <= '0;
        end else if (!stall) begin
            if (ex_valid) begin
                exm_ctrl <= '{valid: 1'b1, wb_en: ex_wb_en, r_en: ex_mem_r_en, w_en: ex_mem_w_en};
                exm_dest <= ex_dest;
                exm_alu  <= ex_alu_res;
                exm_sd   <= fwd_val2;
            end else begin
                exm_ctrl <= '0;
                exm_dest <= '0;
                exm_alu  <= '0;
                exm_sd   <= '0;
            end
        end
    end

    assign memop         = is_memop(exm_ctrl);
    assign MEM_WB_en     = exm_ctrl.valid & exm_ctrl.wb_en;
    assign MEM_dest      = exm_dest;
    assign mem_stage_val = exm_alu;
    assign mem_addr      = exm_alu;
    assign mem_wdata     = exm_sd;
    assign mem_we        = exm_ctrl.w_en;

    mem_access_fsm #(.DATA_W(DATA_W)) u_mem_fsm (
        .clk       (clk),
        .rst       (rst),
        .memop     (memop),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .rdata_q   (rdata_q)
    );

    // a stalled MEM stage feeds a bubble forward so WB retires each op once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_WB_en <= 1'b0;
            WB_dest  <= '0;
            wb_value <= '0;
        end else if (stall) begin
            WB_WB_en <= 1'b0;
        end else begin
            WB_WB_en <= MEM_WB_en;
            WB_dest  <= MEM_dest;
            wb_value <= exm_ctrl.r_en ? rdata_q : exm_alu;
        end
    end

endmodule

// File: tb/tb_exe_mem_backend.sv
// Self-checking bench for exe_mem_backend: a residency-based model of the
// MEM stage checked every cycle, plus literal checks on the directed scenarios.
module tb_exe_mem_backend;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel_src1 = '0, sel_src2 = '0;
    logic [31:0] ex_val1 = '0, ex_val2 = '0, ex_alu_res = '0;
    logic        ex_valid = 1'b0, ex_wb_en = 1'b0, ex_mem_r_en = 1'b0, ex_mem_w_en = 1'b0;
    logic [3:0]  ex_dest = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] fwd_val1, fwd_val2, mem_addr, mem_wdata, mem_stage_val, wb_value;
    logic        mem_req, mem_we, stall, MEM_WB_en, WB_WB_en;
    logic [3:0]  MEM_dest, WB_dest;

    exe_mem_backend dut (
        .clk(clk), .rst(rst),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .ex_val1(ex_val1), .ex_val2(ex_val2),
        .fwd_val1(fwd_val1), .fwd_val2(fwd_val2),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_dest(ex_dest), .ex_alu_res(ex_alu_res),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall),
        .MEM_WB_en(MEM_WB_en), .MEM_dest(MEM_dest),
        .WB_WB_en(WB_WB_en), .WB_dest(WB_dest),
        .mem_stage_val(mem_stage_val), .wb_value(wb_value)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the instruction occupying MEM, how long it has sat there, and
    // whether its memory data has arrived. WB is simply what last left MEM.
    logic        m_v = 0, m_wb = 0, m_r = 0, m_w = 0;
    logic [3:0]  m_dest = '0;
    logic [31:0] m_alu = '0, m_sd = '0, m_data = '0;
    int          m_age = 0;
    logic        m_got = 0;
    logic        w_en = 0;
    logic [3:0]  w_dest = '0;
    logic [31:0] w_val = '0;
    logic        m_st;
    logic [31:0] m_sdn;
    logic        e_memop, e_stall;

    assign e_memop = m_v & (m_r | m_w);
    assign e_stall = e_memop & ~m_got;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] ex);
        if (s == 2'b01) return m_alu;
        if (s == 2'b10) return w_val;
        return ex;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v = 0; m_wb = 0; m_r = 0; m_w = 0; m_dest = '0; m_alu = '0; m_sd = '0;
            m_data = '0; m_age = 0; m_got = 0; w_en = 0; w_dest = '0; w_val = '0;
        end else begin
            m_st  = e_stall;
            m_sdn = pick(sel_src2, ex_val2);
            if (e_memop && !m_got && m_age >= 1 && mem_ready) begin
                m_got  = 1;
                m_data = mem_rdata;
            end
            if (!m_st) begin
                w_en   = m_v & m_wb;
                w_dest = m_dest;
                w_val  = m_r ? m_data : m_alu;
                if (ex_valid) begin
                    m_v = 1; m_wb = ex_wb_en; m_r = ex_mem_r_en; m_w = ex_mem_w_en;
                    m_dest = ex_dest; m_alu = ex_alu_res; m_sd = m_sdn;
                end else begin
                    m_v = 0; m_wb = 0; m_r = 0; m_w = 0; m_dest = '0; m_alu = '0; m_sd = '0;
                end
                m_age = 0;
                m_got = 0;
            end else begin
                w_en = 0;
                m_age++;
            end
        end
    end

    // Memory responder driven from the model's request: ready once the
    // request has been up for lat+1 cycles; optional spurious ready otherwise.
    int   lat  = 1;
    int   rcnt = 0;
    logic spur = 0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEAD;
            32'h100: return 32'h1111;
            32'h104: return 32'h2222;
            default: return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        mem_rdata = rd_of(m_alu);
        if (!rst) begin
            rcnt = 0;
            mem_ready = 0;
        end else if (e_stall) begin
            rcnt++;
            mem_ready = (rcnt >= lat + 1);
        end else begin
            rcnt = 0;
            mem_ready = spur;
        end
    end

    int          n_stall = 0, n_wb = 0, n_req = 0;
    logic        req_d = 0;
    logic [31:0] wb_q[$];
    logic [3:0]  wbd_q[$];

    always @(negedge clk) begin
        chk("fwd_val1", fwd_val1, pick(sel_src1, ex_val1));
        chk("fwd_val2", fwd_val2, pick(sel_src2, ex_val2));
        chk("stall", stall, e_stall);
        chk("mem_req", mem_req, e_stall);
        chk("mem_we", mem_we, m_w);
        chk("mem_addr", mem_addr, m_alu);
        chk("mem_wdata", mem_wdata, m_sd);
        chk("MEM_WB_en", MEM_WB_en, m_v & m_wb);
        chk("MEM_dest", MEM_dest, m_dest);
        chk("mem_stage_val", mem_stage_val, m_alu);
        chk("WB_WB_en", WB_WB_en, w_en);
        chk("WB_dest", WB_dest, w_dest);
        chk("wb_value", wb_value, w_val);
        if (stall) n_stall++;
        if (WB_WB_en) begin
            n_wb++;
            wb_q.push_back(wb_value);
            wbd_q.push_back(WB_dest);
        end
        if (mem_req && !req_d) n_req++;
        req_d = mem_req;
    end

    task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                         input logic [3:0] d, input logic [31:0] alu,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] e1, input logic [31:0] e2);
        ex_valid = v; ex_wb_en = wb; ex_mem_r_en = r; ex_mem_w_en = w;
        ex_dest = d; ex_alu_res = alu;
        sel_src1 = s1; sel_src2 = s2; ex_val1 = e1; ex_val2 = e2;
    endtask

    // returns #1 after the edge on which the EX instruction is accepted
    task automatic advance();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!e_stall) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL advance_timeout: stall=%0b after 40 cycles, required 0", stall);
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 4'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
    endtask

    task automatic clear_counts();
        n_stall = 0; n_wb = 0; n_req = 0;
        wb_q.delete();
        wbd_q.delete();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 32'd0);
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_wb_en", WB_WB_en, 32'd0);
        chk("rst_wb_value", wb_value, 32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU r3=0x10, then dependent op forwarding from MEM
        drive(1, 1, 0, 0, 4'd3, 32'h10, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        drive(1, 1, 0, 0, 4'd4, 32'h20, 2'b01, 2'b00, 32'h99, 32'h0);
        #1;
        chk("dep_fwd_val1", fwd_val1, 32'h10);
        chk("dep_MEM_dest", MEM_dest, 32'd3);
        chk("dep_MEM_WB_en", MEM_WB_en, 32'd1);
        advance();
        chk("dep_WB_dest", WB_dest, 32'd3);
        chk("dep_wb_value", wb_value, 32'h10);
        chk("dep_WB_WB_en", WB_WB_en, 32'd1);

        // forwarding from WB and the 11 select
        drive(1, 1, 0, 0, 4'd6, 32'hAB, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        bubble();
        drive(0, 0, 0, 0, 4'd0, 32'h0, 2'b00, 2'b10, 32'h0, 32'h55);
        #1;
        chk("sel2_wb", fwd_val2, 32'hAB);
        sel_src2 = 2'b11;
        #1;
        chk("sel2_11", fwd_val2, 32'h55);
        bubble();

        // load r5 @0x40, ready two cycles after the request
        lat = 2;
        clear_counts();
        drive(1, 1, 1, 0, 4'd5, 32'h40, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        repeat (3) bubble();
        chk("load_stall_cycles", n_stall, 32'd3);
        chk("load_wb_pulses", n_wb, 32'd1);
        chk("load_wb_dest", (wbd_q.size() > 0) ? wbd_q[0] : 4'hF, 32'd5);
        chk("load_wb_value", (wb_q.size() > 0) ? wb_q[0] : 32'hFFFF_FFFF, 32'hDEAD);

        // store @0x80 whose data is forwarded from the MEM value 0x77
        lat = 0;
        drive(1, 1, 0, 0, 4'd7, 32'h77, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        drive(1, 0, 0, 1, 4'd0, 32'h80, 2'b00, 2'b01, 32'h0, 32'h12);
        advance();
        @(posedge clk);
        #1;
        clear_counts();
        chk("st_wait_req", mem_req, 32'd1);
        chk("st_mem_we", mem_we, 32'd1);
        chk("st_mem_wdata", mem_wdata, 32'h77);
        chk("st_mem_addr", mem_addr, 32'h80);
        repeat (3) bubble();
        chk("st_wb_pulses", n_wb, 32'd0);

        // back-to-back loads with spurious ready outside the wait phase
        lat = 1;
        spur = 1;
        clear_counts();
        drive(1, 1, 1, 0, 4'd8, 32'h100, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        drive(1, 1, 1, 0, 4'd9, 32'h104, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        repeat (3) bubble();
        spur = 0;
        chk("b2b_req_episodes", n_req, 32'd2);
        chk("b2b_stall_cycles", n_stall, 32'd4);
        chk("b2b_wb_pulses", n_wb, 32'd2);
        chk("b2b_wb0_value", (wb_q.size() > 0) ? wb_q[0] : 32'hFFFF_FFFF, 32'h1111);
        chk("b2b_wb1_value", (wb_q.size() > 1) ? wb_q[1] : 32'hFFFF_FFFF, 32'h2222);
        chk("b2b_wb0_dest", (wbd_q.size() > 0) ? wbd_q[0] : 4'hF, 32'd8);
        chk("b2b_wb1_dest", (wbd_q.size() > 1) ? wbd_q[1] : 4'hF, 32'd9);

        // reset asserted while a load is waiting
        lat = 20;
        drive(1, 1, 1, 0, 4'd10, 32'h200, 2'b00, 2'b00, 32'h0, 32'h0);
        advance();
        drive(0, 0, 0, 0, 4'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rstw_mem_req", mem_req, 32'd0);
        chk("rstw_stall", stall, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_mem_req", mem_req, 32'd0);
        chk("post_stall", stall, 32'd0);
        chk("post_mem_we", mem_we, 32'd0);
        chk("post_mem_addr", mem_addr, 32'd0);
        chk("post_mem_wdata", mem_wdata, 32'd0);
        chk("post_MEM_WB_en", MEM_WB_en, 32'd0);
        chk("post_MEM_dest", MEM_dest, 32'd0);
        chk("post_mem_stage_val", mem_stage_val, 32'd0);
        chk("post_WB_WB_en", WB_WB_en, 32'd0);
        chk("post_WB_dest", WB_dest, 32'd0);
        chk("post_wb_value", wb_value, 32'd0);
        chk("post_fwd_val1", fwd_val1, 32'd0);
        chk("post_fwd_val2", fwd_val2, 32'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_mem_backend.md
Name: exe_mem_backend

Overview:
- Back end of the pipeline, directly downstream of the forwarding unit.
- Consumes sel_src1/sel_src2 to pick the ALU operands.
- Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory handshake FSM.
- Produces MEM_WB_en/MEM_dest/WB_WB_en/WB_dest, which feed back into the forwarding unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 4, register-index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 = ID/EX value, 01 = MEM-stage value, 10 = WB value, 11 = ID/EX value.
- ex_val1, ex_val2  in  DATA_W each  unforwarded operands from ID/EX.
- fwd_val1, fwd_val2  out  DATA_W each  forwarded operands to the ALU (combinational).
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en  in  1 each  EX-stage control.
- ex_dest  in  REG_AW  EX-stage destination register.
- ex_alu_res  in  DATA_W  ALU result for the current EX instruction.
- mem_req, mem_we  out  1 each  memory request; write enable.
- mem_addr, mem_wdata  out  DATA_W each  memory address and store data.
- mem_ready  in  1  memory completion strobe.
- mem_rdata  in  DATA_W  memory read data.
- stall  out  1  freeze request to IF/ID/EX.
- MEM_WB_en  out  1  MEM-stage write-back enable.
- MEM_dest  out  REG_AW  MEM-stage destination.
- WB_WB_en  out  1  WB-stage write-back enable.
- WB_dest  out  REG_AW  WB-stage destination.
- mem_stage_val  out  DATA_W  EX/MEM ALU result (forwarding source 01).
- wb_value  out  DATA_W  write-back data (forwarding source 10).

Behaviour:
- Reset: every register, output and the FSM clear to 0 / M_IDLE. mem_req and stall drop asynchronously, including mid-access.
- Forward mux: fwd_val1 and fwd_val2 select by sel per the Ports table.
- EX/MEM register: loads {valid, wb_en, r_en, w_en, dest, alu_res, store data = fwd_val2} when stall=0.
  - While stall=1 it holds its contents.
  - ex_valid=0 loads a bubble: all enables 0.
- MEM_WB_en = EX/MEM.valid & wb_en. MEM_dest = EX/MEM.dest. mem_stage_val = EX/MEM.alu_res.
- A load in MEM forwards its address, not the loaded data. Load-use hazards are handled upstream.
- Memory op present (memop) = EX/MEM.valid & (r_en | w_en).
- FSM states:
  - M_IDLE:
    - memop=1: stall=1, mem_req=1, go to M_WAIT.
    - memop=0: stall=0.
    - mem_ready is ignored in this state.
  - M_WAIT:
    - mem_req=1 and stall=1; mem_addr, mem_wdata and mem_we are held stable.
    - mem_ready=1: latch mem_rdata into rdata_q, go to M_DONE.
  - M_DONE:
    - mem_req=0, stall=0; the pipeline advances.
    - Always returns to M_IDLE.
- Memory-op MEM residency = 2 + (cycles until mem_ready) cycles; minimum 3. Non-memory op residency = 1 cycle.
- mem_addr = EX/MEM.alu_res. mem_wdata = EX/MEM store data. mem_we = EX/MEM.w_en.
- MEM/WB register:
  - When stall=0: loads WB_WB_en = MEM_WB_en, WB_dest = MEM_dest, and wb_value = (r_en ? rdata_q : alu_res).
  - When stall=1: loads a bubble (WB_WB_en=0). The WB instruction retires exactly once.
- Back-to-back memory ops: DONE → IDLE → WAIT. There is no overlap and no lost request.
- mem_ready asserted in M_IDLE or M_DONE is a protocol error and is ignored.
- A store (w_en=1, wb_en=0) produces no write-back.

Decomposition:
- Shared package holds:
  - FSM state encoding (M_IDLE=0, M_WAIT=1, M_DONE=2).
  - Forwarding-select constants (FWD_ID=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10).
  - DATA_W/REG_AW defaults.
- One natural sub-module: mem_access_fsm, which owns the FSM, stall, mem_req and rdata_q.

Test Plan:
- Reset mid-M_WAIT (rst low during a load) -> mem_req=0 and stall=0 immediately; after release, all outputs are 0 and the FSM is in M_IDLE.
- ALU op r3 (ex_alu_res=0x10) followed by a dependent op with sel_src1=01 -> fwd_val1=0x10, MEM_dest=3, MEM_WB_en=1; next cycle WB_dest=3, wb_value=0x10.
- sel_src2=10 with wb_value=0xAB, ex_val2=0x55 -> fwd_val2=0xAB; sel_src2=11 -> fwd_val2=0x55.
- Load r5 at addr 0x40, mem_ready 2 cycles after request with rdata=0xDEAD -> stall high for 3 cycles; WB_WB_en=1 exactly one cycle, WB_dest=5, wb_value=0xDEAD.
- Store at 0x80 with sel_src2=01 (MEM value 0x77) -> mem_we=1, mem_wdata=0x77, mem_addr=0x80 held through M_WAIT; no WB_WB_en pulse.
- Two back-to-back loads, mem_ready=1 on first WAIT cycle each -> two separate mem_req episodes, each 3-cycle residency, two distinct write-backs in order.
